// File: rtl/std_cache_pkg.sv
// Shared cache-bank geometry defaults, lane/injection typedefs and small helpers.
// Parameterised modules take their defaults from here rather than from literals.
package std_cache_pkg;

   localparam int unsigned DefNumWords  = 256;
   localparam int unsigned DefSetAssoc  = 8;
   localparam int unsigned DefLineWidth = 160;
   localparam int unsigned DefBlkWidth  = 8;
   localparam int unsigned DefLatency   = 1;

   localparam logic [15:0] InjCntMax = 16'hFFFF;

   function automatic int unsigned num_lanes(input int unsigned line_w, input int unsigned blk_w);
      return line_w / blk_w;
   endfunction

   localparam int unsigned DefLanes = num_lanes(DefLineWidth, DefBlkWidth);

   typedef logic [DefLanes-1:0] lane_mask_t;

   typedef struct packed {
      logic [$clog2(DefSetAssoc)-1:0]  way;
      logic [$clog2(DefNumWords)-1:0]  addr;
      logic [$clog2(DefLineWidth)-1:0] bit_idx;
   } inj_target_t;

endpackage

// File: rtl/dcache_bank_rd_pipe.sv
// Fixed-latency read return pipe: valid shifts every cycle, data only advances
// behind a valid so the final stage holds the last returned line.
module dcache_bank_rd_pipe
   import std_cache_pkg::*;
#(
   parameter int unsigned Latency = DefLatency,
   parameter int unsigned Width   = DefLineWidth
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic [Latency-1:0] vld_q;
   logic [Width-1:0]   dat_q [Latency];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int i = 0; i < Latency; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= valid_i;
         if (valid_i) dat_q[0] <= data_i;
         for (int i = 1; i < Latency; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[Latency-1];
   assign data_o  = dat_q[Latency-1];

endmodule

// File: rtl/dcache_ecc_bank.sv
// Single-port multi-way data-cache bank with lane-masked writes, fixed-latency
// pipelined reads and a bit-flip fault injector for ECC testing.
module dcache_ecc_bank
   import std_cache_pkg::*;
#(
   parameter int unsigned NumWords  = DefNumWords,
   parameter int unsigned SetAssoc  = DefSetAssoc,
   parameter int unsigned LineWidth = DefLineWidth,
   parameter int unsigned BlkWidth  = DefBlkWidth,
   parameter int unsigned Latency   = DefLatency,
   parameter int unsigned AddrWidth = $clog2(NumWords)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [SetAssoc-1:0]                 req_i,
   input  logic                                we_i,
   input  logic [AddrWidth-1:0]                addr_i,
   input  logic [LineWidth-1:0]                wdata_i,
   input  logic [num_lanes(LineWidth, BlkWidth)-1:0] be_i,
   output logic [SetAssoc-1:0][LineWidth-1:0]  rdata_o,
   output logic [SetAssoc-1:0]                 rvalid_o,
   input  logic                                inj_valid_i,
   input  logic [$clog2(SetAssoc)-1:0]         inj_way_i,
   input  logic [AddrWidth-1:0]                inj_addr_i,
   input  logic [$clog2(LineWidth)-1:0]        inj_bit_i,
   output logic [15:0]                         inj_cnt_o
);

   localparam int unsigned Lanes = num_lanes(LineWidth, BlkWidth);

   logic                 addr_ok;
   logic                 inj_ok;
   logic                 same_word;
   logic [LineWidth-1:0] flip_mask;
   logic [15:0]          inj_cnt_q, inj_cnt_d;

   assign addr_ok   = 32'(addr_i) < NumWords;
   assign inj_ok    = inj_valid_i && (32'(inj_bit_i) < LineWidth)
                    && (32'(inj_addr_i) < NumWords) && (32'(inj_way_i) < SetAssoc);
   assign same_word = (addr_i == inj_addr_i);
   assign flip_mask = {{(LineWidth-1){1'b0}}, 1'b1} << inj_bit_i;

   genvar gi;
   generate
      for (gi = 0; gi < SetAssoc; gi++) begin : g_way
         logic [LineWidth-1:0] mem_q [NumWords];
         logic [LineWidth-1:0] merged;
         logic [LineWidth-1:0] rd_line;
         logic                 wr_hit;
         logic                 inj_hit;
         logic                 rd_req;

         assign wr_hit  = req_i[gi] && we_i && addr_ok;
         assign inj_hit = inj_ok && (32'(inj_way_i) == gi);
         assign rd_req  = req_i[gi] && !we_i;
         assign rd_line = addr_ok ? mem_q[addr_i] : '0;

         always_comb begin
            merged = mem_q[addr_i];
            for (int k = 0; k < Lanes; k++) begin
               if (be_i[k]) merged[k*BlkWidth +: BlkWidth] = wdata_i[k*BlkWidth +: BlkWidth];
            end
         end

         // A flip landing on the word being written is folded into the write data.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int n = 0; n < NumWords; n++) mem_q[n] <= '0;
            end else begin
               if (inj_hit && !(wr_hit && same_word))
                  mem_q[inj_addr_i] <= mem_q[inj_addr_i] ^ flip_mask;
               if (wr_hit)
                  mem_q[addr_i] <= merged ^ ((inj_hit && same_word) ? flip_mask : '0);
            end
         end

         dcache_bank_rd_pipe #(
            .Latency (Latency),
            .Width   (LineWidth)
         ) u_rd_pipe (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (rd_req),
            .data_i  (rd_line),
            .valid_o (rvalid_o[gi]),
            .data_o  (rdata_o[gi])
         );
      end
   endgenerate

   always_comb begin
      inj_cnt_d = inj_cnt_q;
      if (inj_ok && (inj_cnt_q != InjCntMax)) inj_cnt_d = inj_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) inj_cnt_q <= '0;
      else       inj_cnt_q <= inj_cnt_d;
   end

   assign inj_cnt_o = inj_cnt_q;

endmodule

// File: tb/tb_dcache_ecc_bank.sv
// Directed bench: a Latency=1 and a Latency=3 bank share all inputs.
module tb_dcache_ecc_bank;
   import std_cache_pkg::*;

   localparam int NW = DefNumWords;
   localparam int SA = DefSetAssoc;
   localparam int LW = DefLineWidth;
   localparam int BW = DefBlkWidth;
   localparam int NL = LW / BW;
   localparam int AW = $clog2(NW);

   logic                     clk = 1'b0;
   logic                     rst;
   logic [SA-1:0]            req;
   logic                     we;
   logic [AW-1:0]            addr;
   logic [LW-1:0]            wdata;
   logic [NL-1:0]            be;
   logic                     inj_valid;
   logic [$clog2(SA)-1:0]    inj_way;
   logic [AW-1:0]            inj_addr;
   logic [$clog2(LW)-1:0]    inj_bit;
   logic [SA-1:0][LW-1:0]    rdata1, rdata3;
   logic [SA-1:0]            rvalid1, rvalid3;
   logic [15:0]              cnt1, cnt3;

   int checks = 0;
   int errors = 0;

   logic [LW-1:0] exp_be;
   logic [LW-1:0] pat;

   always #5 clk = ~clk;

   dcache_ecc_bank #(.Latency(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .rdata_o(rdata1), .rvalid_o(rvalid1),
      .inj_valid_i(inj_valid), .inj_way_i(inj_way), .inj_addr_i(inj_addr),
      .inj_bit_i(inj_bit), .inj_cnt_o(cnt1)
   );

   dcache_ecc_bank #(.Latency(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .rdata_o(rdata3), .rvalid_o(rvalid3),
      .inj_valid_i(inj_valid), .inj_way_i(inj_way), .inj_addr_i(inj_addr),
      .inj_bit_i(inj_bit), .inj_cnt_o(cnt3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = '0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      inj_valid = 1'b0; inj_way = '0; inj_addr = '0; inj_bit = '0;
   endtask

   task automatic do_write(input logic [SA-1:0] m, input logic [AW-1:0] a,
                           input logic [LW-1:0] d, input logic [NL-1:0] b);
      req = m; we = 1'b1; addr = a; wdata = d; be = b;
      tick();
      idle();
      $display("write ways=%h addr=%h be=%h data=%h", m, a, b, d);
   endtask

   task automatic do_read(input logic [SA-1:0] m, input logic [AW-1:0] a);
      req = m; we = 1'b0; addr = a;
      tick();
      idle();
      $display("read  ways=%h addr=%h rvalid1=%h", m, a, rvalid1);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++; if (rvalid1 !== '0 || rvalid3 !== '0) begin errors++;
         $display("FAIL reset_rvalid got %h/%h want 0", rvalid1, rvalid3); end
      checks++; if (rdata1 !== '0 || rdata3 !== '0) begin errors++;
         $display("FAIL reset_rdata got nonzero want 0"); end
      checks++; if (cnt1 !== 16'd0 || cnt3 !== 16'd0) begin errors++;
         $display("FAIL reset_cnt got %h/%h want 0", cnt1, cnt3); end
      $display("reset applied");
   endtask

   task automatic test_read_zero();
      do_read(8'h01, 8'h00);
      checks++; if (rvalid1 !== 8'h01) begin errors++;
         $display("FAIL rd0_rvalid got %h want 01", rvalid1); end
      checks++; if (rdata1[0] !== '0) begin errors++;
         $display("FAIL rd0_rdata got %h want 0", rdata1[0]); end
      tick();
      checks++; if (rvalid1 !== 8'h00) begin errors++;
         $display("FAIL rd0_single_pulse got %h want 00", rvalid1); end
   endtask

   task automatic test_byte_enable();
      exp_be = '1;
      exp_be[7:0] = 8'h00;
      do_write(8'h08, 8'h12, '1, '1);
      checks++; if (rvalid1 !== 8'h00) begin errors++;
         $display("FAIL wr_no_rvalid got %h want 00", rvalid1); end
      do_write(8'h08, 8'h12, '0, 20'h00001);
      do_read(8'h08, 8'h12);
      checks++; if (rvalid1 !== 8'h08) begin errors++;
         $display("FAIL be_rvalid got %h want 08", rvalid1); end
      checks++; if (rdata1[3] !== exp_be) begin errors++;
         $display("FAIL be_rdata got %h want %h", rdata1[3], exp_be); end
      tick();
      checks++; if (rvalid1 !== 8'h00 || rdata1[3] !== exp_be) begin errors++;
         $display("FAIL be_hold got %h/%h want 00/%h", rvalid1, rdata1[3], exp_be); end
   endtask

   task automatic test_inject();
      pat = {5{32'hDEADBEEF}};
      do_write(8'h02, 8'h05, pat, '1);
      req = 8'h02; we = 1'b0; addr = 8'h05;
      inj_valid = 1'b1; inj_way = 3'd1; inj_addr = 8'h05; inj_bit = 8'd7;
      tick();
      idle();
      $display("read+inject way1 addr05 bit7");
      checks++; if (rdata1[1] !== pat) begin errors++;
         $display("FAIL inj_read_preflip got %h want %h", rdata1[1], pat); end
      do_read(8'h02, 8'h05);
      checks++; if (rdata1[1] !== (pat ^ 160'h80)) begin errors++;
         $display("FAIL inj_flipped got %h want %h", rdata1[1], pat ^ 160'h80); end
      inj_valid = 1'b1; inj_way = 3'd1; inj_addr = 8'h05; inj_bit = 8'd7;
      tick();
      idle();
      $display("inject way1 addr05 bit7");
      do_read(8'h02, 8'h05);
      checks++; if (rdata1[1] !== pat) begin errors++;
         $display("FAIL inj_restored got %h want %h", rdata1[1], pat); end
      checks++; if (cnt1 !== 16'd2) begin errors++;
         $display("FAIL inj_cnt got %0d want 2", cnt1); end
   endtask

   task automatic test_write_inject();
      req = 8'h04; we = 1'b1; addr = 8'h20; wdata = '0; be = '1;
      inj_valid = 1'b1; inj_way = 3'd2; inj_addr = 8'h20; inj_bit = 8'd0;
      tick();
      idle();
      $display("write+inject way2 addr20 bit0");
      do_read(8'h04, 8'h20);
      checks++; if (rdata1[2] !== 160'd1) begin errors++;
         $display("FAIL wr_inj got %h want 1", rdata1[2]); end
      checks++; if (cnt1 !== 16'd3) begin errors++;
         $display("FAIL wr_inj_cnt got %0d want 3", cnt1); end
   endtask

   task automatic test_ignored_inject();
      inj_valid = 1'b1; inj_way = 3'd0; inj_addr = 8'h00; inj_bit = 8'd160;
      tick();
      inj_bit = 8'd255;
      tick();
      idle();
      $display("inject out-of-range bits 160,255");
      checks++; if (cnt1 !== 16'd3) begin errors++;
         $display("FAIL inj_ignored_cnt got %0d want 3", cnt1); end
      do_read(8'h01, 8'h00);
      checks++; if (rdata1[0] !== '0) begin errors++;
         $display("FAIL inj_ignored_data got %h want 0", rdata1[0]); end
   endtask

   task automatic test_multi_way();
      do_read(8'hFF, 8'h12);
      checks++; if (rvalid1 !== 8'hFF) begin errors++;
         $display("FAIL multi_rvalid got %h want ff", rvalid1); end
      checks++; if (rdata1[3] !== exp_be || rdata1[0] !== '0) begin errors++;
         $display("FAIL multi_rdata got %h/%h want %h/0", rdata1[3], rdata1[0], exp_be); end
   endtask

   task automatic test_back_to_back();
      for (int a = 1; a <= 3; a++) do_write(8'h01, AW'(a), {5{32'(a)}}, '1);
      do_write(8'h01, 8'h03, {5{32'h33}}, '1);
      do_read(8'h01, 8'h03);
      checks++; if (rdata1[0] !== {5{32'h33}}) begin errors++;
         $display("FAIL wr_then_rd got %h want %h", rdata1[0], {5{32'h33}}); end
      for (int i = 0; i < 4; i++) tick();
      // three reads on consecutive edges E1..E3
      req = 8'h01; we = 1'b0;
      addr = 8'h01; tick();
      checks++; if (rvalid1 !== 8'h01 || rdata1[0] !== {5{32'd1}} || rvalid3 !== 8'h00) begin errors++;
         $display("FAIL b2b_e1 got %h/%h/%h", rvalid1, rdata1[0], rvalid3); end
      addr = 8'h02; tick();
      checks++; if (rvalid1 !== 8'h01 || rdata1[0] !== {5{32'd2}}) begin errors++;
         $display("FAIL b2b_e2 got %h/%h", rvalid1, rdata1[0]); end
      addr = 8'h03; tick();
      idle();
      checks++; if (rvalid1 !== 8'h01 || rdata1[0] !== {5{32'h33}}) begin errors++;
         $display("FAIL b2b_e3 got %h/%h", rvalid1, rdata1[0]); end
      checks++; if (rvalid3 !== 8'h01 || rdata3[0] !== {5{32'd1}}) begin errors++;
         $display("FAIL lat3_e3 got %h/%h want 01/%h", rvalid3, rdata3[0], {5{32'd1}}); end
      tick();
      checks++; if (rvalid3 !== 8'h01 || rdata3[0] !== {5{32'd2}} || rvalid1 !== 8'h00) begin errors++;
         $display("FAIL lat3_e4 got %h/%h", rvalid3, rdata3[0]); end
      tick();
      checks++; if (rvalid3 !== 8'h01 || rdata3[0] !== {5{32'h33}}) begin errors++;
         $display("FAIL lat3_e5 got %h/%h", rvalid3, rdata3[0]); end
      tick();
      checks++; if (rvalid3 !== 8'h00 || rdata3[0] !== {5{32'h33}}) begin errors++;
         $display("FAIL lat3_hold got %h/%h", rvalid3, rdata3[0]); end
      $display("back-to-back reads addr 1,2,3");
   endtask

   task automatic test_reset_inflight();
      req = 8'h01; we = 1'b0;
      addr = 8'h01; tick();
      addr = 8'h02; tick();
      addr = 8'h03; tick();
      idle();
      checks++; if (rvalid3 !== 8'h01) begin errors++;
         $display("FAIL flush_pre got %h want 01", rvalid3); end
      rst = 1'b1;
      tick();
      checks++; if (rvalid3 !== '0 || rdata3 !== '0 || rvalid1 !== '0 || rdata1 !== '0) begin errors++;
         $display("FAIL flush_outputs got %h/%h want 0", rvalid3, rvalid1); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (rvalid3 !== '0 || rdata3 !== '0 || cnt3 !== 16'd0) begin errors++;
            $display("FAIL flush_after%0d got %h cnt %0d want 0", i, rvalid3, cnt3); end
      end
      do_read(8'h01, 8'h01);
      checks++; if (rvalid1 !== 8'h01 || rdata1[0] !== '0) begin errors++;
         $display("FAIL mem_cleared got %h/%h want 01/0", rvalid1, rdata1[0]); end
      $display("reset with reads in flight");
   endtask

   task automatic test_saturate();
      inj_valid = 1'b1; inj_way = 3'd0; inj_addr = 8'h00; inj_bit = 8'd0;
      for (int i = 0; i < 65534; i++) tick();
      checks++; if (cnt1 !== 16'hFFFE) begin errors++;
         $display("FAIL sat_pre got %h want fffe", cnt1); end
      tick();
      checks++; if (cnt1 !== 16'hFFFF) begin errors++;
         $display("FAIL sat_hit got %h want ffff", cnt1); end
      for (int i = 0; i < 4465; i++) tick();
      idle();
      checks++; if (cnt1 !== 16'hFFFF || cnt3 !== 16'hFFFF) begin errors++;
         $display("FAIL sat_70000 got %h/%h want ffff", cnt1, cnt3); end
      tick();
      checks++; if (cnt1 !== 16'hFFFF) begin errors++;
         $display("FAIL sat_hold got %h want ffff", cnt1); end
      $display("70000 injections, count %h", cnt1);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_read_zero();
      test_byte_enable();
      test_inject();
      test_write_inject();
      test_ignored_inject();
      test_multi_way();
      test_back_to_back();
      test_reset_inflight();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_ecc_bank.md
DCACHE_ECC_BANK -- requirements
Module: dcache_ecc_bank

Interface
REQ-001 SHALL have parameter NumWords, default 256, meaning words (sets) per way.
REQ-002 SHALL have parameter SetAssoc, default 8, meaning number of ways.
REQ-003 SHALL have parameter LineWidth, default 160, meaning stored codeword line width in bits (tag, valid, dirty and ECC data).
REQ-004 SHALL have parameter BlkWidth, default 8, meaning bits per write-enable lane; LineWidth is a multiple of BlkWidth.
REQ-005 SHALL have parameter Latency, default 1, meaning read latency in cycles; legal range 1..3.
REQ-006 SHALL have parameter AddrWidth, default $clog2(NumWords).
REQ-007 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 req_i  in  SetAssoc  per-way request, one-hot or multi-hot.
REQ-010 we_i  in  1  write when high, read when low; applies to all requested ways.
REQ-011 addr_i  in  AddrWidth  word index.
REQ-012 wdata_i  in  LineWidth  write codeword line.
REQ-013 be_i  in  LineWidth/BlkWidth  lane enables; lane k covers bits [k*BlkWidth +: BlkWidth].
REQ-014 rdata_o  out  SetAssoc x LineWidth  per-way read data.
REQ-015 rvalid_o  out  SetAssoc  per-way read-data-valid strobe.
REQ-016 inj_valid_i  in  1  fault-injection request.
REQ-017 inj_way_i, inj_addr_i, inj_bit_i  in  clog2(SetAssoc), AddrWidth, clog2(LineWidth)  injection target.
REQ-018 inj_cnt_o  out  16  saturating count of applied injections.

Function
REQ-019 Bank SHALL be the responder end of the cache bank port: always ready, no grant, accepts one access per cycle.
REQ-020 Write (req_i[w]=1, we_i=1): for each enabled lane SHALL replace the stored bits of way w at addr_i with wdata_i; disabled lanes keep old contents.
REQ-021 Read (req_i[w]=1, we_i=0): rdata_o[w] SHALL present the stored line exactly Latency cycles later with rvalid_o[w]=1 in that cycle only.
REQ-022 Writes SHALL produce no rvalid_o; rdata_o[w] SHALL hold its last value when no read of way w completes.
REQ-023 Read and write of same way/address cannot coincide (single port); a write followed next cycle by a read SHALL return the new data.
REQ-024 Accepted reads SHALL be fully pipelined: back-to-back reads each return after exactly Latency cycles, in order.
REQ-025 Injection SHALL XOR bit inj_bit_i of way inj_way_i, word inj_addr_i at the clock edge where inj_valid_i=1, and SHALL increment inj_cnt_o, saturating at 16'hFFFF.
REQ-026 Injection and write to the same word in the same cycle: write applies first, flip applies to the written result.
REQ-027 Injection and read of the same word in the same cycle: read returns the pre-flip value.
REQ-028 inj_bit_i >= LineWidth or inj_addr_i >= NumWords SHALL be ignored and not counted.
REQ-029 addr_i >= NumWords SHALL be ignored on write; a read SHALL return all-zero with rvalid_o asserted.

Reset
REQ-030 While rst_i=1 at a clock edge: all storage SHALL clear to zero (valid all-zero Hsiao codeword), rdata_o=0, rvalid_o=0, inj_cnt_o=0, read pipeline flushed.
REQ-031 Requests presented during reset SHALL be dropped; reads in flight when reset asserts SHALL never produce rvalid_o.

Structure
REQ-032 Lane-count and injection-target typedefs SHALL live in std_cache_pkg; the module SHALL use no cache-geometry constants directly.
REQ-033 The read delay SHALL be one sub-module, dcache_bank_rd_pipe, parameterised by Latency and width, carrying valid and data.

Verification
REQ-034 Reset, read way0 addr 0x00 -> rvalid_o[0]=1 after Latency cycles, rdata_o[0]=0.
REQ-035 Write way3 addr 0x12 data all-ones, be_i all-ones; then write data 0, be_i only lane 0 set; read -> low 8 bits 0, all others 1.
REQ-036 Inject way1 addr 0x05 bit 7 twice, then read -> original data restored, inj_cnt_o=2.
REQ-037 Write way2 addr 0x20 data 0 with injection of bit 0 at same word in same cycle; read -> value 1.
REQ-038 Latency=3: reads addr 1,2,3 on consecutive cycles; assert rst_i in the cycle after the third read -> no rvalid_o at any later cycle, all outputs 0.
REQ-039 70000 injections -> inj_cnt_o=16'hFFFF and holds.
